// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, systick, LED, 7-seg and switch block.
// Bus: Address/Write_data/MemRead/MemWrite in, Read_data out; IRQ from timer.
module peripheral_bus #(
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  input  logic [7:0]  switch,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        IRQ
);

  localparam logic [15:0] DIV_LAST = 16'(TIMER_DIV - 1);

  localparam logic [7:0] A_TH   = 8'h00;
  localparam logic [7:0] A_TL   = 8'h04;
  localparam logic [7:0] A_TCON = 8'h08;
  localparam logic [7:0] A_LED  = 8'h0C;
  localparam logic [7:0] A_SW   = 8'h10;
  localparam logic [7:0] A_DIGI = 8'h14;
  localparam logic [7:0] A_TICK = 8'h18;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q, systick_d;
  logic [15:0] div_q, div_d;

  logic        sel;
  logic        wr;
  logic        tick;
  logic [31:0] rdata;

  assign sel  = (Address[31:8] == 24'h40_0000);
  assign wr   = MemWrite & sel;
  assign tick = tcon_q[0] & (div_q == DIV_LAST);

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    div_d     = div_q;
    systick_d = systick_q + 32'd1;

    // Disabled timer freezes TL, status and the prescaler.
    if (tcon_q[0]) begin
      div_d = tick ? 16'd0 : div_q + 16'd1;
      if (tick) begin
        if (&tl_q) begin
          tl_d = th_q;
          if (tcon_q[1]) tcon_d[2] = 1'b1;
        end else begin
          tl_d = tl_q + 32'd1;
        end
      end
    end

    // CPU writes land after the timer update so they take priority.
    if (wr) begin
      case (Address[7:0])
        A_TH:    th_d   = Write_data;
        A_TL:    tl_d   = Write_data;
        A_TCON:  tcon_d = Write_data[2:0];
        A_LED:   led_d  = Write_data[7:0];
        A_DIGI:  digi_d = Write_data[11:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      div_q     <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (MemRead && sel) begin
      case (Address[7:0])
        A_TH:    rdata = th_q;
        A_TL:    rdata = tl_q;
        A_TCON:  rdata = {29'd0, tcon_q};
        A_LED:   rdata = {24'd0, led_q};
        A_SW:    rdata = {24'd0, switch};
        A_DIGI:  rdata = {20'd0, digi_q};
        A_TICK:  rdata = systick_q;
        default: rdata = '0;
      endcase
    end
  end

  assign Read_data = rdata;
  assign leds      = led_q;
  assign digi      = digi_q;
  assign IRQ       = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: random and directed checks of two peripheral_bus
// instances (TIMER_DIV 1 and 4) against a cycle-level behavioural model.
module tb_peripheral_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [7:0]  sw = '0;

  logic [31:0] rd0, rd1;
  logic [7:0]  led0, led1;
  logic [11:0] dg0, dg1;
  logic        irq0, irq1;

  always #5 clk = ~clk;

  peripheral_bus #(.TIMER_DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .Address(Address),
    .Write_data(Write_data), .MemRead(MemRead),
    .MemWrite(MemWrite), .Read_data(rd0), .switch(sw),
    .leds(led0), .digi(dg0), .IRQ(irq0)
  );

  peripheral_bus #(.TIMER_DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .Address(Address),
    .Write_data(Write_data), .MemRead(MemRead),
    .MemWrite(MemWrite), .Read_data(rd1), .switch(sw),
    .leds(led1), .digi(dg1), .IRQ(irq1)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Model state per instance: index 0 is TIMER_DIV=1, 1 is TIMER_DIV=4.
  int          divs [2] = '{1, 4};
  logic [31:0] m_th [2];
  logic [31:0] m_tl [2];
  logic        m_en [2];
  logic        m_ie [2];
  logic        m_st [2];
  int          m_div [2];
  logic [7:0]  m_led [2];
  logic [11:0] m_dg [2];
  longint      m_cycles;

  logic [31:0] last0, last1;

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_th[k] = 0; m_tl[k] = 0;
      m_en[k] = 0; m_ie[k] = 0; m_st[k] = 0;
      m_div[k] = 0; m_led[k] = 0; m_dg[k] = 0;
    end
    m_cycles = 0;
  endfunction

  function automatic logic [31:0] m_read(int k, logic [31:0] a,
                                         logic rd);
    if (!rd || a[31:8] != 24'h40_0000) return 0;
    case (a[7:0])
      8'h00: return m_th[k];
      8'h04: return m_tl[k];
      8'h08: return {29'd0, m_st[k], m_ie[k], m_en[k]};
      8'h0C: return {24'd0, m_led[k]};
      8'h10: return {24'd0, sw};
      8'h14: return {20'd0, m_dg[k]};
      8'h18: return 32'(m_cycles % 64'h1_0000_0000);
      default: return 0;
    endcase
  endfunction

  function automatic void m_clock(logic [31:0] a, logic [31:0] wd,
                                  logic wr);
    logic hit;
    hit = wr && a[31:8] == 24'h40_0000;
    m_cycles++;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ntl;
      logic        nst;
      bit          tk;
      ntl = m_tl[k];
      nst = m_st[k];
      tk  = m_en[k] && m_div[k] == divs[k] - 1;
      if (m_en[k]) m_div[k] = (m_div[k] + 1) % divs[k];
      if (tk) begin
        if (m_tl[k] == 32'hFFFF_FFFF) begin
          ntl = m_th[k];
          if (m_ie[k]) nst = 1;
        end else begin
          ntl = m_tl[k] + 1;
        end
      end
      if (hit) begin
        case (a[7:0])
          8'h00: m_th[k] = wd;
          8'h04: ntl = wd;
          8'h08: begin
            m_en[k] = wd[0]; m_ie[k] = wd[1]; nst = wd[2];
          end
          8'h0C: m_led[k] = wd[7:0];
          8'h14: m_dg[k] = wd[11:0];
          default: ;
        endcase
      end
      m_tl[k] = ntl;
      m_st[k] = nst;
    end
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr,
                      input logic rst);
    @(negedge clk);
    Address = a; Write_data = wd;
    MemRead = rd; MemWrite = wr; reset = rst;
    if (!rst) m_reset();
    #1;
    last0 = rd0;
    last1 = rd1;
    chk("rd_d1", rd0, m_read(0, a, rd));
    chk("rd_d4", rd1, m_read(1, a, rd));
    chk("led_d1", {24'd0, led0}, {24'd0, m_led[0]});
    chk("led_d4", {24'd0, led1}, {24'd0, m_led[1]});
    chk("digi_d1", {20'd0, dg0}, {20'd0, m_dg[0]});
    chk("digi_d4", {20'd0, dg1}, {20'd0, m_dg[1]});
    chk("irq_d1", {31'd0, irq0}, {31'd0, m_ie[0] & m_st[0]});
    chk("irq_d4", {31'd0, irq1}, {31'd0, m_ie[1] & m_st[1]});
    @(posedge clk);
    if (rst) m_clock(a, wd, wr);
  endtask

  task automatic wr_reg(input logic [7:0] r, input logic [31:0] d);
    step({24'h40_0000, r}, d, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic rd_reg(input logic [7:0] r);
    step({24'h40_0000, r}, 32'd0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(0, 0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] lows [7] = '{8'h00, 8'h04, 8'h08, 8'h0C,
                           8'h10, 8'h14, 8'h18};

  initial begin
    do_reset();

    // Reset mid-run with TL=5, TCON=3: all registers read zero.
    wr_reg(8'h04, 32'd5);
    wr_reg(8'h08, 32'd3);
    sw = 8'h00;
    for (int i = 0; i < 7; i++)
      step({24'h40_0000, lows[i]}, 0, 1'b1, 1'b0, 1'b0);
    chk("rst_irq", {31'd0, irq0}, 32'd0);
    step(32'h4000_0004, 0, 1'b1, 1'b0, 1'b0);
    chk("rst_tl", last0, 32'd0);

    // Overflow with TIMER_DIV=1.
    wr_reg(8'h00, 32'hFFFF_FFFC);
    wr_reg(8'h04, 32'hFFFF_FFFE);
    wr_reg(8'h08, 32'd3);
    idle(2);
    rd_reg(8'h04);
    chk("ovf_tl", last0, 32'hFFFF_FFFC);
    chk("ovf_irq", {31'd0, irq0}, 32'd1);
    rd_reg(8'h08);
    chk("ovf_tcon", last0, 32'd7);
    wr_reg(8'h08, 32'd3);
    rd_reg(8'h04);
    chk("clr_irq", {31'd0, irq0}, 32'd0);
    chk("clr_tl", last0, 32'hFFFF_FFFF);

    // Prescale with TIMER_DIV=4.
    do_reset();
    wr_reg(8'h04, 32'd0);
    wr_reg(8'h08, 32'd1);
    idle(4);
    rd_reg(8'h04);
    chk("pre_tl1", last1, 32'd1);
    idle(7);
    rd_reg(8'h04);
    chk("pre_tl3", last1, 32'd3);

    // TL write colliding with the overflow tick.
    do_reset();
    wr_reg(8'h00, 32'h55);
    wr_reg(8'h04, 32'hFFFF_FFFE);
    wr_reg(8'h08, 32'd3);
    idle(1);
    wr_reg(8'h04, 32'h1234);
    rd_reg(8'h04);
    chk("col_tl", last0, 32'h1234);
    rd_reg(8'h08);
    chk("col_tcon", last0, 32'd7);

    // Decode.
    wr_reg(8'h0C, 32'h1A5);
    idle(1);
    chk("led_a5", {24'd0, led0}, 32'hA5);
    wr_reg(8'h14, 32'hF3F);
    idle(1);
    chk("digi_f3f", {20'd0, dg0}, 32'hF3F);
    sw = 8'h5C;
    rd_reg(8'h10);
    chk("switch", last0, 32'h5C);
    wr_reg(8'h18, 32'd0);
    step(32'h4000_0020, 0, 1'b1, 1'b0, 1'b1);
    chk("unmap20", last0, 32'd0);
    step(32'h1000_0000, 0, 1'b1, 1'b0, 1'b1);
    chk("unmap_lo", last0, 32'd0);
    step(32'h4000_000C, 0, 1'b0, 1'b0, 1'b1);
    chk("no_read", last0, 32'd0);

    // SYSTICK after 100 cycles.
    do_reset();
    idle(100);
    rd_reg(8'h18);
    chk("tick100", {31'd0, last0 >= 99 && last0 <= 101}, 32'd1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, wd;
      int p;
      p  = $urandom_range(0, 9);
      if (p < 7) a = {24'h40_0000, lows[p]};
      else if (p == 7) a = {24'h40_0000, 8'($urandom)};
      else if (p == 8) a = $urandom;
      else a = {24'h40_0000, 8'h04};
      wd = $urandom;
      if (a[7:0] == 8'h04 && $urandom_range(0, 1) == 1)
        wd = 32'hFFFF_FFFF - $urandom_range(0, 12);
      if (a[7:0] == 8'h08 && $urandom_range(0, 2) != 0)
        wd[0] = 1'b1;
      sw = 8'($urandom);
      step(a, wd, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 399) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
